// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_DWIDTH = 32;
  localparam logic [FETCH_DWIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_DWIDTH-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// In-order fetch buffer: synchronous FIFO of {pc, instr} with flush and a
// first-word-fall-through head that reads as zero while empty.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Flush wins over everything; a push in the flush cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruct_fetch.sv
// RV32I instruction fetch: PC register, fetch buffer handshake to decode, redirect.
// Optional misaligned-redirect trap flag enabled by FETCH_MISALIGN_CHECK_EN.
module instruct_fetch
  import fetch_pkg::*;
#(
  parameter int                DWIDTH    = FETCH_DWIDTH,
  parameter logic [DWIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  output logic [DWIDTH-1:0] Program_Count,
  input  logic [31:0]       Instruction,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Target,
  input  logic              Dec_Ready,
  output logic              Dec_Valid,
  output logic [31:0]       Dec_Instruction,
  output logic [DWIDTH-1:0] Dec_PC
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              Fetch_Misalign
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [DWIDTH-1:0] pc;
  logic [DWIDTH-1:0] redirect_pc;
  logic [CW-1:0]     count;
  logic              empty;
  logic              pop;
  logic              push;
  logic              misalign;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

`ifdef FETCH_MISALIGN_CHECK_EN
  // A misaligned target is kept as-is so the trap handler can see it.
  assign redirect_pc = Redirect_Target;

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N)         misalign <= 1'b0;
    else if (Redirect_Valid) misalign <= |Redirect_Target[1:0];
  end

  assign Fetch_Misalign = misalign;
`else
  assign redirect_pc = Redirect_Target & ~DWIDTH'(INSTR_BYTES - 1);
  assign misalign    = 1'b0;
`endif

  assign pop  = Dec_Valid && Dec_Ready;
  assign push = ((count < DEPTH_C) || pop) && !misalign;

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N)         pc <= RESET_PC;
    else if (Redirect_Valid) pc <= redirect_pc;
    else if (push)           pc <= pc + DWIDTH'(INSTR_BYTES);
  end

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = Instruction;

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buf (
    .clk    (Clk_Core),
    .rst_n  (Rst_Core_N),
    .push   (push),
    .pop    (pop),
    .flush  (Redirect_Valid),
    .wr_data(wr_entry),
    .rd_data(head),
    .count  (count),
    .empty  (empty)
  );

  assign Program_Count   = pc;
  assign Dec_Valid       = !empty;
  assign Dec_Instruction = head.instr;
  assign Dec_PC          = head.pc;

endmodule
